cmos_pixel_pack: RTL

CMOS_PIXEL_PACK -- requirements
Module: cmos_pixel_pack

---
 rtl/cmos_pkg.sv | 14 +
 rtl/cmos_pixel_pack_if.sv | 28 ++
 rtl/cmos_line_chk.sv | 51 +++++
 rtl/cmos_pixel_pack.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cmos_pkg.sv
// cmos_pkg: shared types and defaults for the camera pixel packer.
// Holds the capture FSM state type and the default frame/line constants.
package cmos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int WAIT_FRAME_DEF = 10;
  localparam int H_PIXEL_DEF    = 1024;

endpackage

// File: rtl/cmos_pixel_pack_if.sv
// cmos_pixel_pack_if: camera byte bus in, packed RGB565 frame bus out.
// master = camera/consumer side, slave = the packer.
interface cmos_pixel_pack_if;

  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        cmos_frame_vsync;
  logic        cmos_frame_href;
  logic        cmos_frame_valid;
  logic [15:0] cmos_frame_data;
  logic        line_err;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  cmos_frame_vsync, cmos_frame_href,
    input  cmos_frame_valid, cmos_frame_data,
    input  line_err
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output cmos_frame_vsync, cmos_frame_href,
    output cmos_frame_valid, cmos_frame_data,
    output line_err
  );

endinterface

// File: rtl/cmos_line_chk.sv
// cmos_line_chk: counts valid pixels per line, flags lines != H_PIXEL.
// Ports: clk, rst_n, run, href, valid, vsync_rise in; sticky line_err out.
module cmos_line_chk
  import cmos_pkg::*;
#(
  parameter int H_PIXEL = H_PIXEL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic href,
  input  logic valid,
  input  logic vsync_rise,
  output logic line_err
);

  localparam logic [11:0] H_CNT = 12'(H_PIXEL);

  logic        href_q;
  logic        run_q;
  logic [11:0] pix_cnt;
  logic        href_fall;
  logic        leave_run;
  logic        bad_line;

  assign href_fall = href_q & ~href;
  assign leave_run = run_q & ~run;
  assign bad_line  = href_fall & run & (pix_cnt != H_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q   <= 1'b0;
      run_q    <= 1'b0;
      pix_cnt  <= '0;
      line_err <= 1'b0;
    end else begin
      href_q <= href;
      run_q  <= run;
      if (href_fall)
        pix_cnt <= '0;
      else if (valid)
        pix_cnt <= pix_cnt + 12'd1;
      // set beats clear when both land together
      if (bad_line)
        line_err <= 1'b1;
      else if (vsync_rise | leave_run)
        line_err <= 1'b0;
    end
  end

endmodule

// File: rtl/cmos_pixel_pack.sv
// cmos_pixel_pack: drops WAIT_FRAME frames, packs byte pairs to RGB565.
// Ports: clk, rst_n, capture_start, bus (slave); CMOS_LINE_CHECK_EN adds checker.
module cmos_pixel_pack
  import cmos_pkg::*;
#(
  parameter int WAIT_FRAME = WAIT_FRAME_DEF,
  parameter int H_PIXEL    = H_PIXEL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic capture_start,
  cmos_pixel_pack_if.slave bus
);

  localparam logic [7:0] WAIT_CNT = 8'(WAIT_FRAME);

  logic        vsync_d0, vsync_d1;
  logic        href_d0, href_d1;
  logic [7:0]  data_d0;
  logic        vsync_rise;

  state_t      state, state_nxt;
  logic [7:0]  frame_cnt;
  logic        frame_ok;

  logic        byte_flag;
  logic [7:0]  hi_byte;
  logic        frame_vsync;
  logic        frame_href;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic        line_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d0 <= 1'b0;
      vsync_d1 <= 1'b0;
      href_d0  <= 1'b0;
      href_d1  <= 1'b0;
      data_d0  <= '0;
    end else begin
      vsync_d0 <= bus.cam_vsync;
      vsync_d1 <= vsync_d0;
      href_d0  <= bus.cam_href;
      href_d1  <= href_d0;
      data_d0  <= bus.cam_data;
    end
  end

  assign vsync_rise = vsync_d0 & ~vsync_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (!capture_start)
      frame_cnt <= '0;
    else if (state == WAIT && vsync_rise)
      frame_cnt <= frame_cnt + 8'd1;
  end

  // RUN is taken on the frame boundary after WAIT_FRAME
  // whole frames, so the first passed frame is complete
  always_comb begin
    state_nxt = state;
    if (!capture_start)
      state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE: state_nxt = WAIT;
        WAIT: if (vsync_rise && frame_cnt == WAIT_CNT)
                state_nxt = RUN;
        RUN:  state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // capture_start folded in so an abort blanks outputs at once
  always_comb begin
    frame_ok = (state == RUN) && capture_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_flag   <= 1'b0;
      hi_byte     <= '0;
      frame_vsync <= 1'b0;
      frame_href  <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else begin
      frame_vsync <= vsync_d1 & frame_ok;
      frame_href  <= href_d1 & frame_ok;
      frame_valid <= 1'b0;
      if (!href_d0)
        byte_flag <= 1'b0;
      else begin
        byte_flag <= ~byte_flag;
        if (!byte_flag)
          hi_byte <= data_d0;
        else if (frame_ok) begin
          frame_data  <= {hi_byte, data_d0};
          frame_valid <= 1'b1;
        end
      end
    end
  end

`ifdef CMOS_LINE_CHECK_EN
  cmos_line_chk #(
    .H_PIXEL(H_PIXEL)
  ) u_line_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (frame_ok),
    .href      (href_d1),
    .valid     (frame_valid),
    .vsync_rise(vsync_rise),
    .line_err  (line_err)
  );
`else
  // checker absent: H_PIXEL is non-negative, so this is 0
  assign line_err = (H_PIXEL < 0);
`endif

  assign bus.cmos_frame_vsync = frame_vsync;
  assign bus.cmos_frame_href  = frame_href;
  assign bus.cmos_frame_valid = frame_valid;
  assign bus.cmos_frame_data  = frame_data;
  assign bus.line_err         = line_err;

endmodule
